// File: rtl/cpu_pkg.sv
// cpu_pkg: core-wide constants shared by fetch, the IF/ID queue, decode and the immediate generator.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side and decode-side handshake bundle around the IF/ID queue.
interface if_id_queue_if #(
    parameter int DEPTH = 2,
    parameter int XLEN  = cpu_pkg::XLEN
);
    logic                       fetch_valid_i;
    logic [XLEN-1:0]            fetch_pc_i;
    logic [XLEN-1:0]            fetch_instr_i;
    logic                       fetch_ready_o;
    logic                       dec_valid_o;
    logic [XLEN-1:0]            dec_pc_o;
    logic [XLEN-1:0]            dec_instr_o;
    logic                       dec_ready_i;
    logic                       flush_i;
    logic [$clog2(DEPTH):0]     count_o;

    modport master (
        output fetch_valid_i, fetch_pc_i, fetch_instr_i, dec_ready_i, flush_i,
        input  fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o, count_o
    );

    modport slave (
        input  fetch_valid_i, fetch_pc_i, fetch_instr_i, dec_ready_i, flush_i,
        output fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o, count_o
    );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry {pc, instr} buffer between fetch and decode with one-cycle flush.
module if_id_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = cpu_pkg::XLEN
) (
    input logic         clk_i,
    input logic         rst_i,
    if_id_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic            push, pop;

    // fetch_ready_o comes from registered count only, so a full queue never passes through
    assign q.fetch_ready_o = count < CW'(DEPTH);
    assign q.dec_valid_o   = count != '0;
    assign q.count_o       = count;
    assign q.dec_pc_o      = q.dec_valid_o ? pc_mem[rd_ptr] : '0;
    assign q.dec_instr_o   = q.dec_valid_o ? instr_mem[rd_ptr] : XLEN'(cpu_pkg::NOP_INSTR);
    assign push = q.fetch_valid_i & q.fetch_ready_o & ~q.flush_i;
    assign pop  = q.dec_valid_o & q.dec_ready_i & ~q.flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= q.fetch_pc_i;
            instr_mem[wr_ptr] <= q.fetch_instr_i;
        end
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction buffer between the fetch stage (PC + instruction cache) and the decode stage, replacing a plain IF/ID register. It stores up to DEPTH fetched {pc, instruction} pairs and presents the oldest to decode, where the immediate generator, register file and control unit consume it. Fetch and decode run under a valid/ready handshake, which absorbs instruction-cache miss stalls and hazard stalls independently. A branch flush empties the queue in one cycle.

## Interface
- DEPTH, 2: number of entries; a power of two and at least 2.
- XLEN, 32: width of the PC and instruction.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous reset, active-low; 0 clears all state immediately.
- fetch_valid_i  in  1  the fetch beat on fetch_pc_i/fetch_instr_i is valid (instruction cache hit or refill done).
- fetch_pc_i  in  XLEN  PC of the fetched instruction.
- fetch_instr_i  in  XLEN  fetched instruction word.
- fetch_ready_o  out  1  queue can accept a beat this cycle.
- dec_valid_o  out  1  head entry is valid.
- dec_pc_o  out  XLEN  PC of the head entry.
- dec_instr_o  out  XLEN  instruction of the head entry; 32'h00000013 (NOP) when the queue is empty.
- dec_ready_i  in  1  decode takes the head this cycle; 0 means a hazard stall.
- flush_i  in  1  a taken branch or jump was resolved; discard all entries.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Push = fetch_valid_i & fetch_ready_o & ~flush_i.
- Pop = dec_valid_o & dec_ready_i & ~flush_i.
- fetch_ready_o = (count < DEPTH). It depends only on registered count, never on dec_ready_i or flush_i.
- A full queue accepts no beat, even when a pop happens in the same cycle. There is no full-queue pass-through.
- Storage is DEPTH registered entries with a write pointer wr_ptr and a read pointer rd_ptr. Both pointers wrap modulo DEPTH.
- Push writes {fetch_pc_i, fetch_instr_i} at wr_ptr, then increments wr_ptr.
- Pop increments rd_ptr.
- Count update: count += push − pop. A simultaneous push and pop (queue neither full nor empty) leaves count unchanged.
- dec_valid_o = (count != 0).
- dec_pc_o and dec_instr_o come from the entry at rd_ptr through a combinational mux of registered storage.
- When the queue is empty, dec_instr_o = NOP and dec_pc_o = 0. Decode therefore always sees a legal instruction.
- flush_i has priority over everything else. At the edge it sets count = 0 and rd_ptr = wr_ptr = 0.
  - A fetch beat presented in the same cycle is dropped.
  - A decode handshake in the same cycle is not a pop.
  - Storage contents are don't-care after a flush.
- Reset (rst_i = 0), asynchronous, at any time including mid-stream:
  - count = 0, both pointers = 0.
  - dec_valid_o = 0, dec_instr_o = NOP, dec_pc_o = 0.
  - fetch_ready_o = 1, count_o = 0.
  - Stored entries are don't-care.

## Timing
- Latency is 1 cycle: a beat pushed at edge k is visible on dec_* immediately after edge k.
- Throughput is 1 instruction per cycle when dec_ready_i stays high and fetch delivers every cycle. The steady state then holds 1 entry.
- A decode stall of N cycles backs up at most DEPTH entries. fetch_ready_o falls in the cycle after the queue fills.
- dec_* outputs are stable while dec_valid_o = 1 and dec_ready_i = 0.
- After flush_i at edge k, dec_valid_o = 0 immediately after edge k. The first post-flush beat can push in the cycle after edge k and appears after edge k+1.
- No combinational path runs from any input to fetch_ready_o.

## Structure
- The shared package cpu_pkg holds:
  - XLEN.
  - NOP_INSTR = 32'h00000013.
  - The RV32 opcode constants (sw 7'b0100011, beq 7'b1100011, and others) already used by decode and the immediate generator.
- No sub-module: the pointers, counter and storage array fit in one module.

## Test plan
- Reset, then push pc=0x0 instr=0x00a00093 with dec_ready_i=1: dec_valid_o=1, dec_instr_o=0x00a00093 one cycle later; the next cycle it is empty with dec_instr_o=0x00000013.
- Hold dec_ready_i=0 and push 3 beats (pc 0x0, 0x4, 0x8) with DEPTH=2: fetch_ready_o=0 after 2 pushes; the third beat stays pending. Release the stall: decode sees 0x0, 0x4, 0x8 in order with no duplicates.
- Continuous push and pop for 10 cycles: count_o stays 1 and PCs arrive at 1 instruction per cycle. The pointers wrap without loss.
- With the queue holding 2 entries, assert flush_i while fetch_valid_i=1 (pc 0x40): after the edge count_o=0 and dec_valid_o=0. pc 0x40 never reaches decode; a beat pushed in the next cycle appears normally.
- Assert rst_i=0 between edges while 1 entry is queued: dec_valid_o drops to 0 and dec_instr_o becomes NOP before the next edge; fetch_ready_o=1.
